// File: rtl/elastic_pipeline_sv.sv
// elastic_pipeline_sv
//   Valid/ready pipeline built from STAGES register slices. Each slice is a
//   2-entry skid buffer (main register M plus skid register S). Every ready
//   is decoded from state flops, so no combinational ready path crosses a
//   slice. The pipeline holds at most 2*STAGES words, keeps strict FIFO order
//   and sustains one word per cycle while Out_ready stays high.
//
// Parameters
//   WORD_LENGTH  payload width (>0)
//   STAGES       number of skid-buffer slices (>=1)
//   COUNT_WIDTH  width of Count, derived from STAGES (not overridable)
//
// Ports
//   Clock      in   rising-edge system clock
//   Reset      in   asynchronous reset, active low
//   In_valid   in   upstream word valid
//   In_ready   out  slice 0 can accept (held low while Reset is asserted)
//   In_data    in   upstream payload
//   Out_valid  out  last slice holds a word
//   Out_ready  in   downstream accepts
//   Out_data   out  main register of the last slice (holds when Out_valid=0)
//   Count      out  words held across all slices, 0..2*STAGES
//   Flush      in   synchronous active-high flush; present only when
//                   ELASTIC_PIPELINE_FLUSH_EN is defined
module elastic_pipeline_sv #(
  parameter int WORD_LENGTH = 8,
  parameter int STAGES      = 2,
  localparam int COUNT_WIDTH = $clog2(2 * STAGES + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   In_valid,
  output logic                   In_ready,
  input  logic [WORD_LENGTH-1:0] In_data,
  output logic                   Out_valid,
  input  logic                   Out_ready,
  output logic [WORD_LENGTH-1:0] Out_data,
  output logic [COUNT_WIDTH-1:0] Count
`ifdef ELASTIC_PIPELINE_FLUSH_EN
  ,
  input  logic                   Flush
`endif
);

  if (WORD_LENGTH <= 0) begin : g_bad_word_length
    $error("elastic_pipeline_sv: WORD_LENGTH must be > 0");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("elastic_pipeline_sv: STAGES must be >= 1");
  end

  // Encoding equals the number of words held, so Count is a plain sum.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state [STAGES];
  logic [WORD_LENGTH-1:0] m     [STAGES];
  logic [WORD_LENGTH-1:0] s     [STAGES];
  logic [WORD_LENGTH-1:0] up_d  [STAGES];
  logic [STAGES-1:0]      up_v;
  logic [STAGES-1:0]      dn_r;
  logic [STAGES-1:0]      in_fire;
  logic [STAGES-1:0]      out_fire;
  logic                   armed;
  logic [COUNT_WIDTH-1:0] occ;

  // Neighbour signals are taken straight from the neighbour's state flops
  // rather than from each other, which keeps every ready path one flop deep.
  always_comb begin
    up_v[0] = In_valid & armed;
    up_d[0] = In_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      up_v[k] = (state[k-1] != EMPTY);
      up_d[k] = m[k-1];
    end
    dn_r[STAGES-1] = Out_ready;
    for (int unsigned k = 0; k + 1 < STAGES; k++) begin
      dn_r[k] = (state[k+1] != FULL);
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      in_fire[k]  = up_v[k] & (state[k] != FULL);
      out_fire[k] = (state[k] != EMPTY) & dn_r[k];
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occ = occ + COUNT_WIDTH'(state[k]);
    end
  end

  // armed keeps In_ready low during reset and for the edge that releases it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      armed <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        state[k] <= EMPTY;
        m[k]     <= '0;
        s[k]     <= '0;
      end
    end else begin
      armed <= 1'b1;
`ifdef ELASTIC_PIPELINE_FLUSH_EN
      if (Flush) begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          state[k] <= EMPTY;
        end
      end else
`endif
      begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          case (state[k])
            EMPTY: begin
              if (in_fire[k]) begin
                state[k] <= BUSY;
                m[k]     <= up_d[k];
              end
            end
            BUSY: begin
              if (in_fire[k] && out_fire[k]) begin
                m[k] <= up_d[k];
              end else if (in_fire[k]) begin
                state[k] <= FULL;
                s[k]     <= up_d[k];
              end else if (out_fire[k]) begin
                state[k] <= EMPTY;
              end
            end
            FULL: begin
              if (out_fire[k]) begin
                state[k] <= BUSY;
                m[k]     <= s[k];
              end
            end
            default: state[k] <= state[k];
          endcase
        end
      end
    end
  end

  assign In_ready  = armed & (state[0] != FULL);
  assign Out_valid = (state[STAGES-1] != EMPTY);
  assign Out_data  = m[STAGES-1];
  assign Count     = occ;

endmodule

// File: tb/tb_elastic_pipeline_sv.sv
module tb_elastic_pipeline_sv;

  localparam int WL = 8;
  localparam int ST = 3;
  localparam int CW = $clog2(2 * ST + 1);

  logic          Clock = 1'b0;
  logic          Reset;
  logic          In_valid;
  logic          In_ready;
  logic [WL-1:0] In_data;
  logic          Out_valid;
  logic          Out_ready;
  logic [WL-1:0] Out_data;
  logic [CW-1:0] Count;
`ifdef ELASTIC_PIPELINE_FLUSH_EN
  logic          Flush;
`endif

  always #5 Clock = ~Clock;

  elastic_pipeline_sv #(.WORD_LENGTH(WL), .STAGES(ST)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .In_data  (In_data),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .Out_data (Out_data),
    .Count    (Count)
`ifdef ELASTIC_PIPELINE_FLUSH_EN
    ,
    .Flush    (Flush)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drives n consecutive words base, base+1, ... with Out_ready=1 from an
  // empty pipeline; each word must appear ST edges after it is driven.
  task automatic stream(input logic [7:0] base, input int n);
    for (int c = 1; c <= n + ST; c++) begin
      In_valid  = (c <= n);
      In_data   = (c <= n) ? 8'(base + 8'(c - 1)) : 8'h00;
      Out_ready = 1'b1;
      tick();
      chk("stream in_ready", int'(In_ready), 1);
      if (c >= ST && c <= n + ST - 1) begin
        chk("stream out_valid", int'(Out_valid), 1);
        chk("stream out_data", int'(Out_data), int'(8'(base + 8'(c - ST))));
      end else begin
        chk("stream idle out_valid", int'(Out_valid), 0);
      end
    end
    In_valid = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    int         cnt;
  } vec_t;

  vec_t tbl [14];

  logic [7:0] q[$];
  logic       acc;
  logic       dl;
  int         delivered;
  int         cyc;

  initial begin
    // Fill to capacity with Out_ready=0, hold one extra offered word, then
    // drain; expected values are after each edge, from an empty pipeline.
    tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 2};
    tbl[2]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 3};
    tbl[3]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA1, 4};
    tbl[4]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA1, 5};
    tbl[5]  = '{1'b1, 8'hA6, 1'b0, 1'b0, 1'b1, 8'hA1, 6};
    tbl[6]  = '{1'b1, 8'hA7, 1'b0, 1'b0, 1'b1, 8'hA1, 6};
    tbl[7]  = '{1'b1, 8'hA7, 1'b1, 1'b0, 1'b1, 8'hA2, 5};
    tbl[8]  = '{1'b1, 8'hA7, 1'b1, 1'b0, 1'b1, 8'hA3, 4};
    tbl[9]  = '{1'b1, 8'hA7, 1'b1, 1'b1, 1'b1, 8'hA4, 3};
    tbl[10] = '{1'b1, 8'hA7, 1'b1, 1'b1, 1'b1, 8'hA5, 3};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA6, 2};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA7, 1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA7, 0};

    Reset     = 1'b0;
    In_valid  = 1'b0;
    In_data   = 8'h00;
    Out_ready = 1'b0;
`ifdef ELASTIC_PIPELINE_FLUSH_EN
    Flush     = 1'b0;
`endif

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset in_ready", int'(In_ready), 0);
    end
    chk("reset out_valid", int'(Out_valid), 0);
    chk("reset count", int'(Count), 0);
    chk("reset out_data", int'(Out_data), 0);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("release in_ready before edge", int'(In_ready), 0);
    tick();
    chk("release in_ready", int'(In_ready), 1);
    chk("release count", int'(Count), 0);

    // Capacity / drain table
    for (int i = 0; i < 14; i++) begin
      In_valid  = tbl[i].iv;
      In_data   = tbl[i].id;
      Out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("vec%0d in_ready", i), int'(In_ready), int'(tbl[i].ir));
      chk($sformatf("vec%0d out_valid", i), int'(Out_valid), int'(tbl[i].ov));
      chk($sformatf("vec%0d out_data", i), int'(Out_data), int'(tbl[i].od));
      chk($sformatf("vec%0d count", i), Count, tbl[i].cnt);
    end

    // Back-to-back stream 0x01..0x10
    stream(8'h01, 16);

    // Asynchronous reset in the middle of a stream holding four words
    for (int i = 0; i < 4; i++) begin
      In_valid  = 1'b1;
      In_data   = 8'(8'hC1 + i);
      Out_ready = 1'b0;
      tick();
    end
    In_valid = 1'b0;
    chk("midreset count before", int'(Count), 4);
    #2;
    Reset = 1'b0;
    #1;
    chk("midreset count", int'(Count), 0);
    chk("midreset out_valid", int'(Out_valid), 0);
    chk("midreset out_data", int'(Out_data), 0);
    chk("midreset in_ready", int'(In_ready), 0);
    tick();
    tick();
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    chk("midreset release in_ready", int'(In_ready), 1);
    stream(8'hD0, 4);

`ifdef ELASTIC_PIPELINE_FLUSH_EN
    // Flush with five words held and a word offered on the flush cycle
    for (int i = 0; i < 5; i++) begin
      In_valid  = 1'b1;
      In_data   = 8'(8'hE1 + i);
      Out_ready = 1'b0;
      tick();
    end
    chk("flush count before", int'(Count), 5);
    In_valid  = 1'b1;
    In_data   = 8'hE6;
    Out_ready = 1'b1;
    Flush     = 1'b1;
    tick();
    Flush    = 1'b0;
    In_valid = 1'b0;
    chk("flush count", int'(Count), 0);
    chk("flush out_valid", int'(Out_valid), 0);
    chk("flush in_ready", int'(In_ready), 1);
    stream(8'h60, 3);
`endif

    // Random valid/ready with a scoreboard
    delivered = 0;
    cyc       = 0;
    acc       = 1'b0;
    In_valid  = 1'b0;
    while (delivered < 10000 && cyc < 80000) begin
      if (!In_valid || acc) begin
        In_valid = 1'($urandom_range(0, 1));
        In_data  = 8'($urandom);
      end
      Out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = In_valid & In_ready;
      dl  = Out_valid & Out_ready;
      if (dl) begin
        if (q.size() == 0) chk("random underflow", 1, 0);
        else chk("random data", int'(Out_data), int'(q.pop_front()));
      end
      if (acc) q.push_back(In_data);
      tick();
      cyc++;
      if (dl) delivered++;
      chk("random count", int'(Count), q.size());
    end
    chk("random delivered", delivered, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
